// File: rtl/cache_mem_pkg.sv
// Shared cache/memory definitions: line geometry, address field helpers and responder states.
// Used by the cache side and by the refill responder.
package cache_mem_pkg;

   localparam int DATA_W    = 8;
   localparam int ADDR_W    = 6;
   localparam int BEATS     = 4;
   localparam int OFFSET_W  = $clog2(BEATS);
   localparam int LINE_W    = ADDR_W - OFFSET_W;
   localparam int MEM_DEPTH = 1 << ADDR_W;
   localparam int BCNT_W    = OFFSET_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      RD_BURST,
      WR_BURST,
      WR_ACK
   } resp_state_t;

   function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] addr);
      return LINE_W'(addr >> OFFSET_W);
   endfunction

   function automatic logic [OFFSET_W-1:0] offset_of(input logic [ADDR_W-1:0] addr);
      return OFFSET_W'(addr);
   endfunction

   // Word index never carries into the line field, so bursts stay inside their line.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [LINE_W-1:0]   line,
                                                   input logic [OFFSET_W-1:0] word);
      return {line, word};
   endfunction

endpackage

// File: rtl/ram_array.sv
// Backing store for the responder: synchronous write, combinational read,
// synchronous reset loads each byte with its own address.
module ram_array
   import cache_mem_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= DATA_W'(i);
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/cache_refill_responder.sv
// Memory-side responder: 4-beat line refills and 4-beat write-backs against a 64-byte RAM,
// behind a programmable access latency. Build option CRITICAL_WORD_FIRST_EN: refills start at the requested word.
//
// state    | meaning
// IDLE     | ready for a request (req_ready high)
// WAIT     | counting down the main-memory access latency
// RD_BURST | streaming refill beats, one per cycle
// WR_BURST | absorbing write-back beats on wr_valid
// WR_ACK   | wr_done pulse, then back to IDLE
module cache_refill_responder
   import cache_mem_pkg::*;
#(
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              wr_done,
   output logic              busy
);

   localparam int LAT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
   localparam logic [LAT_W-1:0]    LAT_LOAD  = LAT_W'(LATENCY);
   localparam logic [LAT_W-1:0]    LAT_ONE   = LAT_W'(1);
   localparam logic [BCNT_W-1:0]   BEAT_ONE  = BCNT_W'(1);
   localparam logic [BCNT_W-1:0]   BEAT_END  = BCNT_W'(BEATS);
   localparam logic [BCNT_W-1:0]   BEAT_LAST = BCNT_W'(BEATS - 1);

   resp_state_t          state;
   logic [LINE_W-1:0]    line_q;
   logic                 dir_q;
   logic [LAT_W-1:0]     lat_cnt;
   logic [BCNT_W-1:0]    beat_cnt;
   logic [OFFSET_W-1:0]  start_word;
   logic [OFFSET_W-1:0]  rd_word;
   logic [OFFSET_W-1:0]  wr_word;
   logic [DATA_W-1:0]    ram_rdata;
   logic                 ram_we;

   function automatic resp_state_t burst_state(input logic wr);
      return wr ? WR_BURST : RD_BURST;
   endfunction

`ifdef CRITICAL_WORD_FIRST_EN
   logic [OFFSET_W-1:0] offset_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         offset_q <= '0;
      end else if (state == IDLE && req_valid) begin
         offset_q <= offset_of(req_addr);
      end
   end

   assign start_word = offset_q;
`else
   assign start_word = '0;
`endif

   // Word index wraps modulo BEATS by truncation to the offset width.
   assign rd_word   = start_word + beat_cnt[OFFSET_W-1:0];
   assign wr_word   = beat_cnt[OFFSET_W-1:0];
   assign ram_we    = (state == WR_BURST) && wr_valid;
   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   ram_array u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (ram_we),
      .waddr (word_addr(line_q, wr_word)),
      .wdata (wr_data),
      .raddr (word_addr(line_q, rd_word)),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         line_q   <= '0;
         dir_q    <= 1'b0;
         lat_cnt  <= '0;
         beat_cnt <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         rd_data  <= '0;
         wr_done  <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         wr_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  line_q   <= line_of(req_addr);
                  dir_q    <= req_write;
                  lat_cnt  <= LAT_LOAD;
                  beat_cnt <= '0;
                  state    <= (LATENCY == 0) ? burst_state(req_write) : WAIT;
               end
            end
            WAIT: begin
               lat_cnt <= lat_cnt - LAT_ONE;
               if (lat_cnt == LAT_ONE) begin
                  state <= burst_state(dir_q);
               end
            end
            RD_BURST: begin
               // One extra cycle after the last beat lets rd_valid drop while state returns to IDLE.
               if (beat_cnt == BEAT_END) begin
                  state <= IDLE;
               end else begin
                  rd_valid <= 1'b1;
                  rd_data  <= ram_rdata;
                  rd_last  <= (beat_cnt == BEAT_LAST);
                  beat_cnt <= beat_cnt + BEAT_ONE;
               end
            end
            WR_BURST: begin
               if (wr_valid) begin
                  beat_cnt <= beat_cnt + BEAT_ONE;
                  if (beat_cnt == BEAT_LAST) begin
                     state   <= WR_ACK;
                     wr_done <= 1'b1;
                  end
               end
            end
            WR_ACK: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
